// File: rtl/updi_bit_scheduler.sv
// Shared bit-rate timer for the UPDI single-wire link: grants one UART frame to
// RX or TX, emits per-bit strobes and enforces a guard gap before TX is re-granted.
module updi_bit_scheduler #(
  parameter int DIV        = 16,
  parameter int FRAME_BITS = 12,
  parameter int GUARD      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_req,
  input  logic                          rx_req,
  output logic                          tx_gnt,
  output logic                          rx_gnt,
  output logic                          bit_tick,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic                          frame_done,
  output logic                          collision
);

  localparam int IW = $clog2(FRAME_BITS);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = $clog2(GUARD * DIV + 2);

  localparam logic [PW-1:0] PH_LAST    = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_RX      = PW'(DIV / 2);
  localparam logic [IW-1:0] BIT_LAST   = IW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD * DIV);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GUARD} state_t;
  typedef enum logic       {OWN_TX, OWN_RX}            owner_t;

  state_t         state;
  owner_t         owner;
  logic [PW-1:0]  phase;
  logic [IW-1:0]  bit_cnt;
  logic [GW-1:0]  guard_cnt;

  // The frame cycle counter c is kept as bit_cnt*DIV + phase, so no divider is needed.
  logic          owner_req;
  logic          phase_wrap;
  logic [PW-1:0] phase_nxt;
  logic [IW-1:0] bit_nxt;
  logic          tick_nxt;
  logic          last_now;
  logic          last_nxt;
  logic          grant_ok;

  assign owner_req  = (owner == OWN_RX) ? rx_req : tx_req;
  assign phase_wrap = (phase == PH_LAST);
  assign phase_nxt  = phase_wrap ? '0 : phase + 1'b1;
  assign bit_nxt    = phase_wrap ? bit_cnt + 1'b1 : bit_cnt;
  assign tick_nxt   = (phase_nxt == ((owner == OWN_RX) ? PH_RX : '0));
  assign last_now   = phase_wrap && (bit_cnt == BIT_LAST);
  assign last_nxt   = (phase_nxt == PH_LAST) && (bit_nxt == BIT_LAST);
  // The last guard cycle doubles as the IDLE decision, so a held TX request sees no extra gap.
  assign grant_ok   = rx_req || (tx_req && (state == ST_IDLE || guard_cnt == GW'(1)));

  // NOTE: every register here, outputs included, is assigned with <= so that all
  // next-state decisions read the values from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_TX;
      phase      <= '0;
      bit_cnt    <= '0;
      guard_cnt  <= '0;
      tx_gnt     <= 1'b0;
      rx_gnt     <= 1'b0;
      bit_tick   <= 1'b0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
      collision  <= 1'b0;
    end else begin
      bit_tick   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_GUARD: begin
          if (grant_ok) begin
            state     <= ST_RUN;
            owner     <= rx_req ? OWN_RX : OWN_TX;
            tx_gnt    <= !rx_req;
            rx_gnt    <= rx_req;
            bit_tick  <= !rx_req;
            bit_idx   <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            guard_cnt <= '0;
            collision <= 1'b0;
          end else if (state == ST_GUARD) begin
            guard_cnt <= guard_cnt - 1'b1;
            if (guard_cnt == GW'(1)) state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (owner == OWN_TX && rx_req) collision <= 1'b1;
          if (!owner_req || last_now) begin
            tx_gnt <= 1'b0;
            rx_gnt <= 1'b0;
            if (GUARD == 0) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_GUARD;
              guard_cnt <= GUARD_LOAD;
            end
          end else begin
            phase      <= phase_nxt;
            bit_cnt    <= bit_nxt;
            bit_tick   <= tick_nxt;
            frame_done <= last_nxt;
            if (tick_nxt) bit_idx <= bit_nxt;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_bit_scheduler.sv
// Directed bench for updi_bit_scheduler at DIV=4, FRAME_BITS=12, GUARD=2:
// arbitration table plus hand-written frame, guard, collision, abort and reset sequences.
module tb_updi_bit_scheduler;

  localparam int DIV = 4;
  localparam int FB  = 12;
  localparam int GRD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req, rx_req;
  logic       tx_gnt, rx_gnt, bit_tick, frame_done, collision;
  logic [3:0] bit_idx;

  int unsigned total  = 0;
  int unsigned passed = 0;

  updi_bit_scheduler #(.DIV(DIV), .FRAME_BITS(FB), .GUARD(GRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_req     (tx_req),
    .rx_req     (rx_req),
    .tx_gnt     (tx_gnt),
    .rx_gnt     (rx_gnt),
    .bit_tick   (bit_tick),
    .bit_idx    (bit_idx),
    .frame_done (frame_done),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tx;
    logic rx;
    logic exp_tx_gnt;
    logic exp_rx_gnt;
  } arb_vec_t;

  arb_vec_t arb_tab[4];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tx_req = 1'b0;
    rx_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Checks ncyc cycles of a frame starting at c=0 against the expected bit schedule.
  task automatic run_frame(input bit is_rx, input int ncyc, input int pulse_c,
                           input int coll_from, input int drop_c);
    logic [8:0] exp_v, act_v;
    logic       exp_tick;
    for (int c = 0; c < ncyc; c++) begin
      exp_tick = is_rx ? ((c % DIV) == DIV / 2) : ((c % DIV) == 0);
      exp_v = {~is_rx, is_rx, exp_tick, exp_tick ? 4'(c / DIV) : 4'd0,
               c == FB * DIV - 1, coll_from >= 0 && c >= coll_from};
      act_v = {tx_gnt, rx_gnt, bit_tick, bit_tick ? bit_idx : 4'd0, frame_done, collision};
      check($sformatf("%s frame c=%0d", is_rx ? "rx" : "tx", c), act_v, exp_v);
      if (pulse_c >= 0 && c == pulse_c)          rx_req = 1'b1;
      else if (pulse_c >= 0 && c == pulse_c + 1) rx_req = 1'b0;
      if (c == drop_c) begin
        if (is_rx) rx_req = 1'b0;
        else       tx_req = 1'b0;
      end
      step();
    end
  endtask

  // Called on the first cycle after a frame: expects GRD*DIV idle cycles, then a TX grant.
  task automatic guard_then_tx();
    for (int i = 0; i < GRD * DIV; i++) begin
      check($sformatf("guard gap %0d", i), {tx_gnt, rx_gnt}, 2'b00);
      step();
    end
    check("tx grant after guard", {tx_gnt, rx_gnt, bit_tick}, 3'b101);
  endtask

  initial begin
    arb_tab[0] = '{tx: 1'b0, rx: 1'b0, exp_tx_gnt: 1'b0, exp_rx_gnt: 1'b0};
    arb_tab[1] = '{tx: 1'b1, rx: 1'b0, exp_tx_gnt: 1'b1, exp_rx_gnt: 1'b0};
    arb_tab[2] = '{tx: 1'b0, rx: 1'b1, exp_tx_gnt: 1'b0, exp_rx_gnt: 1'b1};
    arb_tab[3] = '{tx: 1'b1, rx: 1'b1, exp_tx_gnt: 1'b0, exp_rx_gnt: 1'b1};

    rst    = 1'b1;
    tx_req = 1'b0;
    rx_req = 1'b0;
    #2;
    check("reset outputs", {tx_gnt, rx_gnt, bit_tick, bit_idx, frame_done, collision}, 9'd0);

    // IDLE arbitration: grant follows the request by one cycle, RX wins ties.
    foreach (arb_tab[i]) begin
      do_reset();
      check($sformatf("arb %0d idle", i), {tx_gnt, rx_gnt}, 2'b00);
      tx_req = arb_tab[i].tx;
      rx_req = arb_tab[i].rx;
      step();
      check($sformatf("arb %0d gnt", i), {tx_gnt, rx_gnt, collision},
            {arb_tab[i].exp_tx_gnt, arb_tab[i].exp_rx_gnt, 1'b0});
    end

    // Full TX frame, then a held request re-granted after the guard.
    do_reset();
    tx_req = 1'b1;
    step();
    run_frame(1'b0, FB * DIV, -1, -1, -1);
    guard_then_tx();

    // Full RX frame.
    do_reset();
    rx_req = 1'b1;
    step();
    run_frame(1'b1, FB * DIV, -1, -1, -1);
    check("rx gnt falls", {tx_gnt, rx_gnt, frame_done}, 3'b000);

    // Simultaneous requests: RX first, TX after the guard.
    do_reset();
    tx_req = 1'b1;
    rx_req = 1'b1;
    step();
    run_frame(1'b1, FB * DIV, -1, -1, -1);
    rx_req = 1'b0;
    guard_then_tx();

    // RX pulse during a TX frame sets a sticky collision, cleared on the next grant.
    do_reset();
    tx_req = 1'b1;
    step();
    run_frame(1'b0, FB * DIV, 10, 11, -1);
    check("collision sticky", collision, 1'b1);
    guard_then_tx();
    check("collision cleared", collision, 1'b0);

    // Abort at c=9, then an RX request cancels the guard.
    do_reset();
    tx_req = 1'b1;
    step();
    run_frame(1'b0, 10, -1, -1, 9);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort quiet %0d", i), {tx_gnt, rx_gnt, bit_tick, frame_done}, 4'b0000);
      if (i == 2) rx_req = 1'b1;
      step();
    end
    run_frame(1'b1, FB * DIV, -1, -1, -1);
    rx_req = 1'b0;

    // Asynchronous reset in the middle of an RX frame.
    do_reset();
    rx_req = 1'b1;
    step();
    run_frame(1'b1, 20, -1, -1, -1);
    rst = 1'b1;
    #1;
    check("async reset", {tx_gnt, rx_gnt, bit_tick, bit_idx, frame_done, collision}, 9'd0);
    rx_req = 1'b0;
    tx_req = 1'b1;
    step();
    rst = 1'b0;
    check("post reset idle", tx_gnt, 1'b0);
    step();
    check("post reset tx gnt", {tx_gnt, rx_gnt, bit_tick, bit_idx}, 7'b1010000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
